// File: rtl/fu_writeback_buffer.sv
// fu_writeback_buffer
// Result-side buffer for a fixed-latency, non-stallable FP functional unit.
// Every result the unit emits is pushed into a small circular FIFO and drained
// to the writeback/ROB port under a valid/ready handshake. An issue-side credit
// counter (ops issued but not yet returned) throttles dispatch through busy_o
// so the FIFO cannot overflow, since the unit itself cannot be stalled.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   issue_valid_i   : op dispatched to the FU this cycle
//   busy_o          : dispatch must hold off (queued + in-flight >= DEPTH)
//   fu_*_i          : result from the FU (valid, dest, ticket, data, exc, cause)
//   wb_valid_o/_ready_i : head-of-queue handshake to writeback
//   wb_*_o          : head entry fields
//   count_o         : FIFO occupancy
//   err_o           : sticky protocol-violation flag (cleared only by rst)
module fu_writeback_buffer #(
  parameter int DATA_W   = 32,
  parameter int DEST_W   = 6,
  parameter int TICKET_W = 4,
  parameter int CAUSE_W  = 4,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid_i,
  output logic                       busy_o,
  input  logic                       fu_valid_i,
  input  logic [DEST_W-1:0]          fu_dest_i,
  input  logic [TICKET_W-1:0]        fu_ticket_i,
  input  logic [DATA_W-1:0]          fu_data_i,
  input  logic                       fu_exc_i,
  input  logic [CAUSE_W-1:0]         fu_cause_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [DEST_W-1:0]          wb_dest_o,
  output logic [TICKET_W-1:0]        wb_ticket_o,
  output logic [DATA_W-1:0]          wb_data_o,
  output logic                       wb_exc_o,
  output logic [CAUSE_W-1:0]         wb_cause_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [DEST_W-1:0]   dest;
    logic [TICKET_W-1:0] ticket;
    logic [DATA_W-1:0]   data;
    logic                exc;
    logic [CAUSE_W-1:0]  cause;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             fu_entry;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic               err_q, err_d;
  logic [CNT_W:0]     credit_sum;
  logic               full, push, pop;
  logic               overflow, underflow, issue_viol;

  assign fu_entry = '{dest: fu_dest_i, ticket: fu_ticket_i, data: fu_data_i,
                      exc: fu_exc_i, cause: fu_cause_i};

  // Credits count both queued and in-flight results; summed one bit wider so
  // the comparison cannot wrap.
  assign credit_sum = {1'b0, count_q} + {1'b0, inflight_q};
  assign busy_o     = (credit_sum >= (CNT_W+1)'(DEPTH));

  assign full       = (count_q == CNT_W'(DEPTH));
  assign wb_valid_o = (count_q != '0);
  assign pop        = wb_valid_o && wb_ready_i;
  // A result arriving while full is dropped; pointers and count stay put.
  assign push       = fu_valid_i && !full;
  assign overflow   = fu_valid_i && full;
  assign underflow  = fu_valid_i && (inflight_q == '0);
  assign issue_viol = issue_valid_i && busy_o;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    err_d      = err_q | overflow | underflow | issue_viol;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Issue and return in the same cycle cancel; otherwise saturate at both ends.
    case ({issue_valid_i, fu_valid_i})
      2'b10: if (inflight_q != CNT_W'(DEPTH)) inflight_d = inflight_q + CNT_W'(1);
      2'b01: if (inflight_q != '0)            inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the storage array is reset so the payload outputs read zero after
  // reset instead of stale or unknown data; this costs a reset net per flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= fu_entry;
    end
  end

  // Head fields come straight from storage: a push writes a different slot
  // (or lands behind an empty queue), so it never disturbs the presented head.
  assign head        = mem_q[rd_ptr_q];
  assign wb_dest_o   = head.dest;
  assign wb_ticket_o = head.ticket;
  assign wb_data_o   = head.data;
  assign wb_exc_o    = head.exc;
  assign wb_cause_o  = head.cause;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_fu_writeback_buffer.sv
// Directed testbench for fu_writeback_buffer (DEPTH = 4). Inputs are driven
// 1 ns after the rising edge; outputs are sampled at that same point, which is
// after the edge has updated all registered state.
module tb_fu_writeback_buffer;

  localparam int DATA_W   = 32;
  localparam int DEST_W   = 6;
  localparam int TICKET_W = 4;
  localparam int CAUSE_W  = 4;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = $clog2(DEPTH+1);

  logic                clk = 1'b0;
  logic                rst;
  logic                issue_valid_i;
  logic                busy_o;
  logic                fu_valid_i;
  logic [DEST_W-1:0]   fu_dest_i;
  logic [TICKET_W-1:0] fu_ticket_i;
  logic [DATA_W-1:0]   fu_data_i;
  logic                fu_exc_i;
  logic [CAUSE_W-1:0]  fu_cause_i;
  logic                wb_valid_o;
  logic                wb_ready_i;
  logic [DEST_W-1:0]   wb_dest_o;
  logic [TICKET_W-1:0] wb_ticket_o;
  logic [DATA_W-1:0]   wb_data_o;
  logic                wb_exc_o;
  logic [CAUSE_W-1:0]  wb_cause_o;
  logic [CNT_W-1:0]    count_o;
  logic                err_o;

  int errors = 0;
  int checks = 0;

  fu_writeback_buffer #(
    .DATA_W(DATA_W), .DEST_W(DEST_W), .TICKET_W(TICKET_W),
    .CAUSE_W(CAUSE_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .busy_o(busy_o),
    .fu_valid_i(fu_valid_i), .fu_dest_i(fu_dest_i), .fu_ticket_i(fu_ticket_i),
    .fu_data_i(fu_data_i), .fu_exc_i(fu_exc_i), .fu_cause_i(fu_cause_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_dest_o(wb_dest_o), .wb_ticket_o(wb_ticket_o), .wb_data_o(wb_data_o),
    .wb_exc_o(wb_exc_o), .wb_cause_o(wb_cause_o),
    .count_o(count_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue_valid_i = 1'b0;
    fu_valid_i    = 1'b0;
    fu_dest_i     = '0;
    fu_ticket_i   = '0;
    fu_data_i     = '0;
    fu_exc_i      = 1'b0;
    fu_cause_i    = '0;
    wb_ready_i    = 1'b0;
  endtask

  task automatic apply_reset;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_result(input int ticket, input int data, input int dest);
    fu_valid_i  = 1'b1;
    fu_ticket_i = TICKET_W'(ticket);
    fu_data_i   = DATA_W'(data);
    fu_dest_i   = DEST_W'(dest);
    fu_exc_i    = 1'b0;
    fu_cause_i  = '0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL init_valid: got %b want 0", wb_valid_o); end
    checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL init_count: got %0d want 0", count_o); end
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL init_busy_err: got busy=%b err=%b want 0 0", busy_o, err_o); end
    checks++; if (wb_data_o !== 32'h0 || wb_ticket_o !== 4'h0) begin errors++; $display("FAIL init_payload: got data=%h ticket=%h want 0", wb_data_o, wb_ticket_o); end
    // Queue two entries, then pull reset in the middle of a cycle.
    issue_valid_i = 1'b1; tick(); tick();
    issue_valid_i = 1'b0;
    push_result(1, 32'hAAAA_0001, 1); tick();
    push_result(2, 32'hAAAA_0002, 2); tick();
    idle();
    checks++; if (count_o !== 3'd2 || wb_valid_o !== 1'b1) begin errors++; $display("FAIL reset_prefill: got count=%0d valid=%b want 2 1", count_o, wb_valid_o); end
    #3 rst = 1'b1;
    #1;
    checks++; if (wb_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL async_reset_q: got valid=%b count=%0d want 0 0", wb_valid_o, count_o); end
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got busy=%b err=%b want 0 0", busy_o, err_o); end
    checks++; if (wb_data_o !== 32'h0 || wb_dest_o !== 6'h0 || wb_ticket_o !== 4'h0) begin errors++; $display("FAIL async_reset_payload: got data=%h dest=%h ticket=%h want 0", wb_data_o, wb_dest_o, wb_ticket_o); end
    #2;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wb_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL post_reset_quiet%0d: got valid=%b count=%0d want 0 0", i, wb_valid_o, count_o); end
    end
  endtask

  task automatic test_single;
    idle();
    issue_valid_i = 1'b1; tick();
    issue_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_issue: got %b want 0", busy_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL single_wait%0d: got valid=%b busy=%b want 0 0", i, wb_valid_o, busy_o); end
    end
    push_result(3, 32'h3F80_0000, 5);
    wb_ready_i = 1'b1;
    checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b want 0", wb_valid_o); end
    tick();
    fu_valid_i = 1'b0;
    checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", wb_valid_o); end
    checks++; if (wb_data_o !== 32'h3F80_0000 || wb_dest_o !== 6'd5 || wb_ticket_o !== 4'd3) begin errors++; $display("FAIL single_fields: got data=%h dest=%0d ticket=%0d want 3f800000 5 3", wb_data_o, wb_dest_o, wb_ticket_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy_head: got %b want 0", busy_o); end
    tick();
    checks++; if (wb_valid_o !== 1'b0 || count_o !== 3'd0) begin errors++; $display("FAIL single_one_beat: got valid=%b count=%0d want 0 0", wb_valid_o, count_o); end
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL single_end_flags: got busy=%b err=%b want 0 0", busy_o, err_o); end
    idle();
  endtask

  task automatic test_fill;
    idle();
    for (int i = 0; i < 4; i++) begin
      issue_valid_i = 1'b1; tick();
      checks++; if (busy_o !== (i == 3)) begin errors++; $display("FAIL fill_busy_issue%0d: got %b want %b", i, busy_o, (i == 3)); end
    end
    issue_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_result(i, 32'h0000_0100 + i, 10 + i); tick();
      checks++; if (count_o !== CNT_W'(i + 1) || busy_o !== 1'b1 || wb_ticket_o !== 4'd0) begin errors++; $display("FAIL fill_push%0d: got count=%0d busy=%b head=%0d want %0d 1 0", i, count_o, busy_o, wb_ticket_o, i + 1); end
    end
    fu_valid_i = 1'b0;
    tick(); tick();
    checks++; if (wb_ticket_o !== 4'd0 || wb_data_o !== 32'h100 || wb_dest_o !== 6'd10 || count_o !== 3'd4) begin errors++; $display("FAIL fill_head_stable: got ticket=%0d data=%h dest=%0d count=%0d want 0 100 10 4", wb_ticket_o, wb_data_o, wb_dest_o, count_o); end
    wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (wb_valid_o !== 1'b1 || wb_ticket_o !== 4'(i) || wb_data_o !== 32'h100 + i) begin errors++; $display("FAIL fill_drain%0d: got valid=%b ticket=%0d data=%h want 1 %0d %h", i, wb_valid_o, wb_ticket_o, wb_data_o, i, 32'h100 + i); end
      tick();
      if (i == 0) begin
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fill_busy_release: got %b want 0", busy_o); end
      end
    end
    checks++; if (wb_valid_o !== 1'b0 || count_o !== 3'd0 || err_o !== 1'b0) begin errors++; $display("FAIL fill_end: got valid=%b count=%0d err=%b want 0 0 0", wb_valid_o, count_o, err_o); end
    idle();
  endtask

  // 14 results: the first 11 cycles stream with ready held high (simultaneous
  // push/pop), then ready alternates while the last results drain.
  task automatic test_stream;
    logic [TICKET_W-1:0] exp_t[$];
    logic [DATA_W-1:0]   exp_d[$];
    int k;
    int popped;
    k = 0;
    popped = 0;
    idle();
    for (int c = 0; c < 21; c++) begin
      issue_valid_i = (c <= 13);
      wb_ready_i    = (c <= 10) ? 1'b1 : (c % 2 == 0);
      fu_valid_i    = 1'b0;
      if (c >= 1 && c <= 14) begin
        push_result(k, 32'hC0DE_0000 + k, k);
        exp_t.push_back(TICKET_W'(k));
        exp_d.push_back(32'hC0DE_0000 + k);
        k++;
      end
      if (wb_valid_o && wb_ready_i) begin
        checks++;
        if (exp_t.size() == 0) begin
          errors++; $display("FAIL stream_spurious c%0d: got ticket=%0d want none", c, wb_ticket_o);
        end else begin
          if (wb_ticket_o !== exp_t[0] || wb_data_o !== exp_d[0]) begin errors++; $display("FAIL stream_order c%0d: got ticket=%0d data=%h want %0d %h", c, wb_ticket_o, wb_data_o, exp_t[0], exp_d[0]); end
          void'(exp_t.pop_front());
          void'(exp_d.pop_front());
          popped++;
        end
      end
      tick();
    end
    idle();
    checks++; if (popped != 14 || exp_t.size() != 0) begin errors++; $display("FAIL stream_count: got popped=%0d left=%0d want 14 0", popped, exp_t.size()); end
    checks++; if (count_o !== 3'd0 || err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL stream_end: got count=%0d err=%b busy=%b want 0 0 0", count_o, err_o, busy_o); end
  endtask

  task automatic test_exception;
    idle();
    issue_valid_i = 1'b1; tick(); tick();
    issue_valid_i = 1'b0;
    push_result(7, 32'h7F80_0001, 20);
    fu_exc_i = 1'b1; fu_cause_i = 4'h2;
    tick();
    push_result(8, 32'h4000_0000, 21);
    tick();
    fu_valid_i = 1'b0;
    checks++; if (wb_exc_o !== 1'b1 || wb_cause_o !== 4'h2 || wb_ticket_o !== 4'd7) begin errors++; $display("FAIL exc_head: got exc=%b cause=%h ticket=%0d want 1 2 7", wb_exc_o, wb_cause_o, wb_ticket_o); end
    wb_ready_i = 1'b1; tick();
    checks++; if (wb_exc_o !== 1'b0 || wb_cause_o !== 4'h0 || wb_ticket_o !== 4'd8 || wb_valid_o !== 1'b1) begin errors++; $display("FAIL exc_next: got exc=%b cause=%h ticket=%0d valid=%b want 0 0 8 1", wb_exc_o, wb_cause_o, wb_ticket_o, wb_valid_o); end
    tick();
    checks++; if (wb_valid_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL exc_end: got valid=%b err=%b want 0 0", wb_valid_o, err_o); end
    idle();
  endtask

  task automatic test_violations;
    idle();
    for (int i = 0; i < 4; i++) begin issue_valid_i = 1'b1; tick(); end
    issue_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin push_result(i, 32'hD00 + i, i); tick(); end
    checks++; if (count_o !== 3'd4 || err_o !== 1'b0) begin errors++; $display("FAIL ovf_prefill: got count=%0d err=%b want 4 0", count_o, err_o); end
    push_result(9, 32'hDEAD_BEEF, 9); tick();
    fu_valid_i = 1'b0;
    checks++; if (err_o !== 1'b1 || count_o !== 3'd4 || wb_ticket_o !== 4'd0) begin errors++; $display("FAIL ovf_flag: got err=%b count=%0d head=%0d want 1 4 0", err_o, count_o, wb_ticket_o); end
    wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (wb_ticket_o !== 4'(i) || wb_data_o !== 32'hD00 + i) begin errors++; $display("FAIL ovf_drain%0d: got ticket=%0d data=%h want %0d %h", i, wb_ticket_o, wb_data_o, i, 32'hD00 + i); end
      tick();
    end
    checks++; if (wb_valid_o !== 1'b0 || err_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got valid=%b err=%b want 0 1", wb_valid_o, err_o); end
    // Underflow: a result with nothing in flight is still queued.
    apply_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL unf_cleared: got %b want 0", err_o); end
    push_result(5, 32'h1234_5678, 3); tick();
    fu_valid_i = 1'b0;
    checks++; if (err_o !== 1'b1 || count_o !== 3'd1 || wb_ticket_o !== 4'd5 || wb_data_o !== 32'h1234_5678) begin errors++; $display("FAIL unf_queued: got err=%b count=%0d ticket=%0d data=%h want 1 1 5 12345678", err_o, count_o, wb_ticket_o, wb_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL unf_inflight_sat: got busy=%b want 0", busy_o); end
    for (int i = 0; i < 3; i++) begin issue_valid_i = 1'b1; tick(); end
    issue_valid_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL unf_credits: got busy=%b want 1", busy_o); end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_exception();
    test_violations();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fu_writeback_buffer.md
# fu_writeback_buffer

Result-side companion of a fixed-latency, non-stallable floating-point functional unit. It captures every `ex_update`-style result the unit emits, queues it in a small FIFO and drains it to the writeback/ROB port under a valid/ready handshake. An issue-side credit counter guarantees the FIFO can never overflow, because the unit itself cannot be back-pressured.

## Interface

**Parameters**
- `DATA_W`, 32: result data width.
- `DEST_W`, 6: destination register tag width.
- `TICKET_W`, 4: ROB ticket width.
- `CAUSE_W`, 4: exception cause width.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

**Ports**
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `issue_valid_i`, in, 1: an op is dispatched to the FU this cycle.
- `busy_o`, out, 1: issue must not assert `issue_valid_i` this cycle.
- `fu_valid_i`, in, 1: FU result valid.
- `fu_dest_i`, in, DEST_W: result destination.
- `fu_ticket_i`, in, TICKET_W: result ticket.
- `fu_data_i`, in, DATA_W: result data.
- `fu_exc_i`, in, 1: result raised an exception.
- `fu_cause_i`, in, CAUSE_W: exception cause.
- `wb_valid_o`, out, 1: head entry is valid.
- `wb_ready_i`, in, 1: writeback accepts the head.
- `wb_dest_o`, `wb_ticket_o`, `wb_data_o`, `wb_exc_o`, `wb_cause_o`, out, field widths as above: head entry fields.
- `count_o`, out, $clog2(DEPTH+1): FIFO occupancy.
- `err_o`, out, 1: sticky protocol-violation flag.

## Operation

**State**
- Circular FIFO of DEPTH entries {dest, ticket, data, exc, cause}.
- Read and write pointers, $clog2(DEPTH) bits each, wrapping modulo DEPTH.
- `count`.
- `inflight` counter, $clog2(DEPTH+1) bits: ops issued but not yet returned by the FU.
- `err` flag.

**Push and pop**
- Push: `fu_valid_i` = 1 writes the entry at the write pointer, then increments the write pointer.
- Pop: `wb_valid_o && wb_ready_i` advances the read pointer.
- `wb_valid_o` = (count != 0).
- `wb_*` fields come from the entry at the read pointer.

**Occupancy update**
- Push and pop in the same cycle: count unchanged.
- Push only: count + 1. Pop only: count − 1.
- Push and pop in the same cycle with count = 1: count stays 1 and the new entry becomes the head in the next cycle.

**Credits**
- `inflight` += `issue_valid_i`, −= `fu_valid_i`. Both in the same cycle: unchanged.
- `busy_o` = (count + inflight ≥ DEPTH). It is combinational from registered state only and never depends on `issue_valid_i` or `wb_ready_i`.
- Conservative: a pop in the current cycle does not release a credit until the next cycle.

**Violations** (set `err`; `err` stays set until `rst`)
- Push while count = DEPTH: the entry is dropped and pointers and count are unchanged.
- `fu_valid_i` with `inflight` = 0: `inflight` saturates at 0 and the push still occurs if count < DEPTH.
- `issue_valid_i` while `busy_o`: `inflight` increments, saturating at DEPTH.

**Head stability**
- While `wb_valid_o && !wb_ready_i`, all `wb_*` outputs are stable.
- A simultaneous push never disturbs the head.

**Reset** (asynchronous)
- Pointers, count, `inflight` and `err` = 0.
- `wb_valid_o` = 0, `busy_o` = 0, `count_o` = 0, `err_o` = 0.
- Payload outputs = 0; the storage array is cleared.
- Reset asserted mid-operation discards all queued and in-flight results. Results the FU emits after reset for ops issued before it are flagged as underflow (`err`).

## Timing

- There is no combinational bypass.
- A result pushed in cycle N with the FIFO empty gives `wb_valid_o` = 1 in cycle N+1.
- Pop takes effect at the edge where `wb_valid_o && wb_ready_i`; the next entry is presented in the following cycle.
- Sustained throughput is one result per cycle in and out.
- `busy_o` reflects pushes, pops and issues one cycle after they occur.
- There are no combinational paths from `wb_ready_i` or `issue_valid_i` to any output.

## Test plan

1. **Reset check.** Assert `rst` mid-cycle with 2 entries queued.
   - Required: all outputs drop to 0 asynchronously and `count_o` = 0.
   - After release, no `wb_valid_o` appears until a new push.
2. **Single result.** One issue, then `fu_valid_i` 4 cycles later with data 0x3F800000, dest 5, ticket 3, and `wb_ready_i` = 1.
   - Required: `wb_valid_o` for exactly one cycle, one cycle after the push, with matching fields.
   - `inflight` returns to 0 and `busy_o` = 0 throughout.
3. **Backpressure and fill** (DEPTH = 4).
   - Issue 4 ops on consecutive cycles with `wb_ready_i` = 0.
   - Required: `busy_o` = 1 from the cycle after the 4th issue.
   - All 4 results are queued in order, `count_o` = 4, and the head is stable.
   - Then raise `wb_ready_i`: results drain in 4 cycles in ticket order, and `busy_o` deasserts the cycle after the first pop.
4. **Simultaneous push/pop and wrap-around.** Stream 10 results with `wb_ready_i` = 1 continuously, then toggle `wb_ready_i` with a 50% pattern.
   - Required: order preserved across pointer wrap, no drops, `err_o` = 0.
5. **Overflow violation.**
   - Force a push with count = 4: `err_o` = 1 and stays set, and the queued entries are unchanged.
   - Force `fu_valid_i` with `inflight` = 0: `err_o` = 1, `inflight` stays 0, and the entry is queued.
6. **Exception propagation.** A result with `fu_exc_i` = 1 and cause 0x2.
   - Required: `wb_exc_o` = 1 and `wb_cause_o` = 0x2 on the same head beat; a following normal result has `wb_exc_o` = 0.
